// File: rtl/mem_lat_model.sv
// mem_lat_model
//   Unified instruction/data memory model with combinational multi-port
//   instruction fetch and a pipelined data port that has a fixed load latency.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   instr_addr       NUM_FETCH packed fetch byte addresses (port i at [32i+:32])
//   instr_rdata      NUM_FETCH packed fetch words (NOP_WORD when out of range)
//   data_req_valid   data request present
//   data_req_ready   request can be accepted this cycle (low in reset/stall)
//   data_addr        data byte address
//   data_wdata       store data, byte lanes aligned to the word
//   data_we          per-byte store enables; nonzero means store
//   data_re          load request; ignored when data_we is nonzero
//   data_rsp_valid   load response valid
//   data_rsp_ready   consumer accepts the response
//   data_rdata       load response word (0 when data_rsp_valid is low)
//   data_err         sticky out-of-range access flag
//   load_cnt         accepted-load counter (wraps)
//   store_cnt        accepted-store counter (wraps)
module mem_lat_model #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned NUM_FETCH   = 2,
    parameter int unsigned LOAD_LAT    = 1,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [32*NUM_FETCH-1:0] instr_addr,
    output logic [32*NUM_FETCH-1:0] instr_rdata,
    input  logic                    data_req_valid,
    output logic                    data_req_ready,
    input  logic [31:0]             data_addr,
    input  logic [31:0]             data_wdata,
    input  logic [3:0]              data_we,
    input  logic                    data_re,
    output logic                    data_rsp_valid,
    input  logic                    data_rsp_ready,
    output logic [31:0]             data_rdata,
    output logic                    data_err,
    output logic [31:0]             load_cnt,
    output logic [31:0]             store_cnt
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    // Load pipeline; the last stage drives the response.
    logic        pv [LOAD_LAT];
    logic [31:0] pd [LOAD_LAT];

    logic          stall;
    logic          acc_store;
    logic          acc_load;
    logic          data_ok;
    logic [AW-1:0] data_idx;
    logic [31:0]   fa;

    function automatic logic in_range(input logic [31:0] a);
        return {2'b00, a[31:2]} < DEPTH_WORDS;
    endfunction

    assign stall          = pv[LOAD_LAT-1] && !data_rsp_ready;
    assign data_req_ready = !rst && !stall;
    assign acc_store      = data_req_valid && data_req_ready && (data_we != 4'b0000);
    assign acc_load       = data_req_valid && data_req_ready && (data_we == 4'b0000) && data_re;
    assign data_ok        = in_range(data_addr);
    assign data_idx       = data_addr[AW+1:2];

    assign data_rsp_valid = pv[LOAD_LAT-1];
    assign data_rdata     = pv[LOAD_LAT-1] ? pd[LOAD_LAT-1] : '0;

    always_comb begin
        instr_rdata = '0;
        fa          = '0;
        for (int unsigned i = 0; i < NUM_FETCH; i++) begin
            fa = instr_addr[32*i +: 32];
            instr_rdata[32*i +: 32] = in_range(fa) ? mem[fa[AW+1:2]] : NOP_WORD;
        end
    end

    // Memory is deliberately not reset; contents are preloaded externally.
    always_ff @(posedge clk) begin
        if (acc_store && data_ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_we[b]) begin
                    mem[data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Whole pipeline advances only outside stall, so nothing in flight can be
    // overwritten or dropped while the head waits for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LOAD_LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else if (!stall) begin
            pv[0] <= acc_load;
            pd[0] <= (acc_load && data_ok) ? mem[data_idx] : '0;
            for (int unsigned i = 1; i < LOAD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_err  <= 1'b0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if ((acc_load || acc_store) && !data_ok) data_err <= 1'b1;
            if (acc_load)  load_cnt  <= load_cnt + 32'd1;
            if (acc_store) store_cnt <= store_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_lat_model.sv
// tb_mem_lat_model
//   Directed bench. Two instances share the data-request inputs:
//   u1 (LOAD_LAT=1, NUM_FETCH=4) and u3 (LOAD_LAT=3, NUM_FETCH=2).
//   Each scenario checks only the instance it targets.
module tb_mem_lat_model;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         data_req_valid = 1'b0;
    logic [31:0]  data_addr = '0;
    logic [31:0]  data_wdata = '0;
    logic [3:0]   data_we = '0;
    logic         data_re = 1'b0;
    logic         data_rsp_ready = 1'b1;

    logic [127:0] instr_addr1 = '0;
    logic [127:0] instr_rdata1;
    logic         req_ready1, rsp_valid1, err1;
    logic [31:0]  rdata1, load_cnt1, store_cnt1;

    logic [63:0]  instr_addr3 = '0;
    logic [63:0]  instr_rdata3;
    logic         req_ready3, rsp_valid3, err3;
    logic [31:0]  rdata3, load_cnt3, store_cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_lat_model #(.DEPTH_WORDS(4096), .NUM_FETCH(4), .LOAD_LAT(1), .NOP_WORD(32'h00000013)) u1 (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr1), .instr_rdata(instr_rdata1),
        .data_req_valid(data_req_valid), .data_req_ready(req_ready1),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we), .data_re(data_re),
        .data_rsp_valid(rsp_valid1), .data_rsp_ready(data_rsp_ready), .data_rdata(rdata1),
        .data_err(err1), .load_cnt(load_cnt1), .store_cnt(store_cnt1)
    );

    mem_lat_model #(.DEPTH_WORDS(4096), .NUM_FETCH(2), .LOAD_LAT(3), .NOP_WORD(32'h00000013)) u3 (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr3), .instr_rdata(instr_rdata3),
        .data_req_valid(data_req_valid), .data_req_ready(req_ready3),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we), .data_re(data_re),
        .data_rsp_valid(rsp_valid3), .data_rsp_ready(data_rsp_ready), .data_rdata(rdata3),
        .data_err(err3), .load_cnt(load_cnt3), .store_cnt(store_cnt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_req_valid = 1'b0;
        data_we        = 4'h0;
        data_re        = 1'b0;
        data_addr      = '0;
        data_wdata     = '0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        data_req_valid = 1'b1;
        data_addr      = a;
        data_wdata     = d;
        data_we        = we;
        data_re        = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] a);
        data_req_valid = 1'b1;
        data_addr      = a;
        data_wdata     = '0;
        data_we        = 4'h0;
        data_re        = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        data_rsp_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        checks++;
        if (rsp_valid1 !== 1'b0 || rdata1 !== 32'h0 || req_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_u1_rsp: valid=%b rdata=%h ready=%b required 0/0/0", rsp_valid1, rdata1, req_ready1);
        end
        checks++;
        if (err1 !== 1'b0 || load_cnt1 !== 32'h0 || store_cnt1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_u1_cnt: err=%b load=%0d store=%0d required 0/0/0", err1, load_cnt1, store_cnt1);
        end
        checks++;
        if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b0 || err3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_u3: valid=%b ready=%b err=%b required 0/0/0", rsp_valid3, req_ready3, err3);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", req_ready1);
        end
    endtask

    // Store, then load of the same word on the very next cycle (LOAD_LAT=1).
    task automatic test_store_load();
        drive_store(32'h100, 32'hDEADBEEF, 4'hF);
        step();
        checks++;
        if (rsp_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL sl_no_rsp_for_store: valid=%b required 0", rsp_valid1);
        end
        drive_load(32'h100);
        step();
        idle();
        checks++;
        if (rsp_valid1 !== 1'b1 || rdata1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sl_rsp: valid=%b rdata=%h required 1/deadbeef", rsp_valid1, rdata1);
        end
        checks++;
        if (store_cnt1 !== 32'd1 || load_cnt1 !== 32'd1) begin
            errors++;
            $display("FAIL sl_counters: store=%0d load=%0d required 1/1", store_cnt1, load_cnt1);
        end
        step();
        checks++;
        if (rsp_valid1 !== 1'b0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL sl_rsp_drop: valid=%b rdata=%h required 0/0", rsp_valid1, rdata1);
        end
    endtask

    task automatic test_byte_lanes();
        drive_store(32'h40, 32'h0000AA00, 4'b0010);
        step();
        drive_load(32'h40);
        step();
        idle();
        checks++;
        if (rsp_valid1 !== 1'b1 || rdata1 !== 32'h1122AA44) begin
            errors++;
            $display("FAIL byte_lanes: valid=%b rdata=%h required 1/1122aa44", rsp_valid1, rdata1);
        end
        step();
    endtask

    // Four back-to-back loads on u3 with two cycles of backpressure once the
    // first response appears; the driver holds a request until it is accepted.
    task automatic test_back_to_back();
        logic [31:0] exp [4];
        int nsent = 0;
        int nrcv = 0;
        int stall_left = 0;
        int stall_seen = 0;
        bit started = 1'b0;
        exp[0] = 32'hA5000020;
        exp[1] = 32'hA5000021;
        exp[2] = 32'hA5000022;
        exp[3] = 32'hA5000023;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (nsent < 4) drive_load(32'h80 + 32'(4 * nsent));
            else idle();
            if (rsp_valid3 && !started) begin
                started    = 1'b1;
                stall_left = 2;
            end
            data_rsp_ready = (stall_left == 0);
            @(negedge clk);
            if (stall_left > 0) begin
                stall_seen++;
                checks++;
                if (req_ready3 !== 1'b0 || rsp_valid3 !== 1'b1 || rdata3 !== exp[0]) begin
                    errors++;
                    $display("FAIL b2b_stall: ready=%b valid=%b rdata=%h required 0/1/%h", req_ready3, rsp_valid3, rdata3, exp[0]);
                end
            end
            if (rsp_valid3 && data_rsp_ready) begin
                checks++;
                if (nrcv >= 4) begin
                    errors++;
                    $display("FAIL b2b_extra: response %0d rdata=%h required none", nrcv, rdata3);
                end else if (rdata3 !== exp[nrcv]) begin
                    errors++;
                    $display("FAIL b2b_order: response %0d rdata=%h required %h", nrcv, rdata3, exp[nrcv]);
                end
                nrcv++;
            end
            if (data_req_valid && req_ready3) nsent++;
            if (stall_left > 0) stall_left--;
            step();
        end
        idle();
        data_rsp_ready = 1'b1;
        checks++;
        if (nrcv !== 4 || nsent !== 4 || stall_seen !== 2) begin
            errors++;
            $display("FAIL b2b_count: rcv=%0d sent=%0d stall=%0d required 4/4/2", nrcv, nsent, stall_seen);
        end
        checks++;
        if (load_cnt3 !== 32'd4) begin
            errors++;
            $display("FAIL b2b_load_cnt: got %0d required 4", load_cnt3);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL oor_pre: err=%b required 0", err1);
        end
        instr_addr1[31:0] = 32'h00004000;
        drive_load(32'h00004000);
        step();
        idle();
        checks++;
        if (err1 !== 1'b1 || rsp_valid1 !== 1'b1 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL oor_load: err=%b valid=%b rdata=%h required 1/1/0", err1, rsp_valid1, rdata1);
        end
        checks++;
        if (instr_rdata1[31:0] !== 32'h00000013) begin
            errors++;
            $display("FAIL oor_fetch: got %h required 00000013", instr_rdata1[31:0]);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (err1 !== 1'b1 || load_cnt1 !== 32'd1) begin
            errors++;
            $display("FAIL oor_sticky: err=%b load=%0d required 1/1", err1, load_cnt1);
        end
        // Out-of-range store must not alias onto word 0.
        drive_store(32'h00004000, 32'hFFFFFFFF, 4'hF);
        step();
        idle();
        instr_addr1[31:0] = 32'h0;
        #1;
        checks++;
        if (instr_rdata1[31:0] !== 32'hA5000000 || store_cnt1 !== 32'd1) begin
            errors++;
            $display("FAIL oor_store: word0=%h store=%0d required a5000000/1", instr_rdata1[31:0], store_cnt1);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] exp [4];
        exp[0] = 32'h1122AA44;
        exp[1] = 32'hDEADBEEF;
        exp[2] = 32'hA5000020;
        exp[3] = 32'hA5000021;
        instr_addr1 = {32'h00000087, 32'h00000080, 32'h00000100, 32'h00000042};
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_rdata1[32*i +: 32] !== exp[i]) begin
                errors++;
                $display("FAIL fetch_port%0d: got %h required %h", i, instr_rdata1[32*i +: 32], exp[i]);
            end
        end
        instr_addr1 = '0;
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        do_reset();
        drive_load(32'h80);
        step();
        drive_load(32'h84);
        step();
        idle();
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b0 || load_cnt3 !== 32'h0 || store_cnt3 !== 32'h0) begin
            errors++;
            $display("FAIL rst_inflight_hold: valid=%b ready=%b load=%0d store=%0d required 0/0/0/0", rsp_valid3, req_ready3, load_cnt3, store_cnt3);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid3 !== 1'b0) seen++;
            step();
        end
        checks++;
        if (seen !== 0 || load_cnt3 !== 32'h0 || store_cnt3 !== 32'h0) begin
            errors++;
            $display("FAIL rst_inflight_after: rsp_cycles=%0d load=%0d store=%0d required 0/0/0", seen, load_cnt3, store_cnt3);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            u1.mem[i] = 32'hA5000000 | 32'(i);
            u3.mem[i] = 32'hA5000000 | 32'(i);
        end
        u1.mem[16] = 32'h11223344;
        #2;
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_fetch();
        test_back_to_back();
        test_out_of_range();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_lat_model.md
MEM_LAT_MODEL -- requirements
Module: mem_lat_model

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 4096, number of 32-bit words in the unified array (power of two).
REQ-002 SHALL provide parameter NUM_FETCH, default 2, number of independent instruction fetch ports (1-4).
REQ-003 SHALL provide parameter LOAD_LAT, default 1, load response latency in cycles (1-4).
REQ-004 SHALL provide parameter NOP_WORD, default 32'h00000013, value returned for out-of-range fetches.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_addr  in  32*NUM_FETCH  fetch byte addresses; port i occupies bits [32i+31:32i].
- instr_rdata  out  32*NUM_FETCH  fetch words, same packing.
- data_req_valid  in  1  data request present.
- data_req_ready  out  1  request can be accepted this cycle.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data, byte lanes aligned to the word.
- data_we  in  4  per-byte store enables; nonzero means store.
- data_re  in  1  load request; ignored when data_we is nonzero.
- data_rsp_valid  out  1  load response valid.
- data_rsp_ready  in  1  consumer accepts the response.
- data_rdata  out  32  load response word.
- data_err  out  1  sticky out-of-range access flag.
- load_cnt  out  32  accepted-load counter.
- store_cnt  out  32  accepted-store counter.

Function
REQ-006 Fetch SHALL be combinational: instr_rdata[i] = mem[instr_addr[i][31:2]] when the word index < DEPTH_WORDS, else NOP_WORD; addr[1:0] ignored.
REQ-007 Accept SHALL occur on a rising edge where data_req_valid && data_req_ready && (data_we != 0 || data_re).
REQ-008 Accepted store SHALL write only the byte lanes whose data_we bit is set, at the accept edge; no response is generated.
REQ-009 Accepted load SHALL sample the full word at the accept edge into a LOAD_LAT-deep valid/data pipeline; data_rsp_valid SHALL rise LOAD_LAT cycles after the accept cycle when there is no backpressure.
REQ-010 Stall SHALL be defined as data_rsp_valid && !data_rsp_ready; during stall every pipeline stage holds its content and data_req_ready = 0.
REQ-011 Outside stall, data_req_ready SHALL be 1; throughput is one accepted request per cycle.
REQ-012 Responses SHALL return in accept order, with no loss or duplication under any backpressure pattern.
REQ-013 A load accepted on the cycle after a store to the same word SHALL return the post-store data.
REQ-014 An accepted access whose word index is >= DEPTH_WORDS SHALL set data_err at that edge and SHALL NOT modify memory.
- If it is a load, it still produces a response with data_rdata = 0.
REQ-015 data_err SHALL remain set until reset.
REQ-016 load_cnt and store_cnt SHALL increment by 1 per accepted load or store, including out-of-range ones, and SHALL wrap modulo 2^32.
REQ-017 data_rdata SHALL be 0 whenever data_rsp_valid = 0.
REQ-018 Memory contents SHALL NOT be reset; the bench initialises the array by hierarchical backdoor before reset is released.

Reset
REQ-019 While rst = 1, the following SHALL hold: all pipeline valids = 0, data_rsp_valid = 0, data_rdata = 0, data_err = 0, load_cnt = 0, store_cnt = 0, data_req_ready = 0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight loads immediately; no response appears after deassertion.
REQ-021 The first accept SHALL be possible on the first rising edge after rst falls.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- LOAD_LAT=1: store 0xDEADBEEF, we=4'hF, to 0x100, then load 0x100 next cycle -> rsp_valid one cycle after the load is accepted, rdata=0xDEADBEEF, store_cnt=1, load_cnt=1.
- Byte lanes: mem[0x40]=0x11223344, store we=4'b0010, wdata=0x0000AA00 -> load returns 0x1122AA44.
- LOAD_LAT=3: loads on 4 consecutive cycles, rsp_ready held 0 for 2 cycles once the first response is valid -> req_ready low during the stall, all 4 responses in order, none dropped.
- Out of range, DEPTH_WORDS=4096: load at 0x00004000 -> data_err=1, response rdata=0; fetch at the same address -> 0x00000013; data_err still 1 after 10 idle cycles.
- NUM_FETCH=4: four distinct fetch addresses in one cycle -> four correct words simultaneously.
- Reset with 2 loads in flight -> no rsp_valid after release, counters 0.
